// File: rtl/pkt_arbiter.sv
// rtl/pkt_arbiter.sv - two-port packet arbiter with round-robin grant and over-length truncation; TSN_PRIORITY_EN adds TSN-first grant
module pkt_arbiter #(
    parameter int unsigned MAX_LEN = 1600
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic        i_p0_pkt_ready,
    input  logic [8:0]  iv_p0_data,
    input  logic        i_p0_tsn,
    input  logic [18:0] iv_p0_ts,
    output logic        o_p0_rd,

    input  logic        i_p1_pkt_ready,
    input  logic [8:0]  iv_p1_data,
    input  logic        i_p1_tsn,
    input  logic [18:0] iv_p1_ts,
    output logic        o_p1_rd,

    input  logic        i_out_ready,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [18:0] ov_rec_ts,
    output logic        o_tsn_en,
    output logic        o_pkt_pulse,
    output logic        o_err_pulse,
    output logic [1:0]  ov_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRAN    = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Index of the last byte a packet may carry before it is cut short.
    localparam logic [10:0] LAST_IDX = 11'(MAX_LEN - 1);

    // Control state
    logic [1:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic        tsn_q, tsn_d;
    logic        last_grant_q, last_grant_d;
    logic [10:0] cnt_q, cnt_d;

    // Registered output stage
    logic [8:0]  data_q, data_d;
    logic        wr_q, wr_d;
    logic [18:0] ts_q, ts_d;
    logic        tsn_en_q, tsn_en_d;
    logic        pkt_pulse_q, pkt_pulse_d;
    logic        err_pulse_q, err_pulse_d;

    // Arbitration and datapath helpers
    logic        any_ready;
    logic        grant;
    logic        grant_tsn;
    logic        popping;
    logic [8:0]  psel_data;
    logic [18:0] psel_ts;
    logic        first_byte;
    logic        at_limit;

    // Pick the port to serve next; only consumed while sitting in IDLE
    always_comb begin
        any_ready = i_p0_pkt_ready | i_p1_pkt_ready;
        if (i_p0_pkt_ready && i_p1_pkt_ready) begin
            // Tie: the port that did not win last time goes now.
            grant = ~last_grant_q;
        end else begin
            grant = i_p1_pkt_ready;
        end
`ifdef TSN_PRIORITY_EN
        // A lone TSN head packet overrides the round-robin order.
        if ((i_p0_pkt_ready & i_p0_tsn) ^ (i_p1_pkt_ready & i_p1_tsn)) begin
            grant = i_p1_pkt_ready & i_p1_tsn;
        end
`endif
        grant_tsn = grant ? i_p1_tsn : i_p0_tsn;
    end

    // Selected-port view of the FIFO heads and the pop strobes
    always_comb begin
        psel_data  = sel_q ? iv_p1_data : iv_p0_data;
        psel_ts    = sel_q ? iv_p1_ts : iv_p0_ts;
        popping    = (state_q == ST_TRAN) || (state_q == ST_DISCARD);
        o_p0_rd    = popping & ~sel_q;
        o_p1_rd    = popping & sel_q;
        first_byte = (cnt_q == 11'd0);
        at_limit   = (cnt_q == LAST_IDX);
    end

    // Next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tsn_d        = tsn_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        data_d       = 9'd0;
        wr_d         = 1'b0;
        ts_d         = 19'd0;
        tsn_en_d     = tsn_en_q;
        pkt_pulse_d  = 1'b0;
        err_pulse_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_out_ready && any_ready) begin
                    sel_d        = grant;
                    tsn_d        = grant_tsn;
                    last_grant_d = grant;
                    state_d      = ST_TRAN;
                end
            end
            ST_TRAN: begin
                data_d = psel_data;
                wr_d   = 1'b1;
                cnt_d  = cnt_q + 11'd1;
                if (first_byte) begin
                    ts_d     = psel_ts;
                    tsn_en_d = tsn_q;
                end
                if (psel_data[8]) begin
                    pkt_pulse_d = 1'b1;
                    state_d     = ST_GAP;
                end else if (at_limit) begin
                    // Over-length: close the packet here, drop the rest upstream.
                    data_d[8]   = 1'b1;
                    pkt_pulse_d = 1'b1;
                    err_pulse_d = 1'b1;
                    state_d     = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (psel_data[8]) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tsn_en_d = 1'b0;
                cnt_d    = 11'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            tsn_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 11'd0;
            data_q       <= 9'd0;
            wr_q         <= 1'b0;
            ts_q         <= 19'd0;
            tsn_en_q     <= 1'b0;
            pkt_pulse_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tsn_q        <= tsn_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            ts_q         <= ts_d;
            tsn_en_q     <= tsn_en_d;
            pkt_pulse_q  <= pkt_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign ov_data     = data_q;
    assign o_data_wr   = wr_q;
    assign ov_rec_ts   = ts_q;
    assign o_tsn_en    = tsn_en_q;
    assign o_pkt_pulse = pkt_pulse_q;
    assign o_err_pulse = err_pulse_q;
    assign ov_state    = state_q;

endmodule

// File: tb/tb_pkt_arbiter.sv
// tb/tb_pkt_arbiter.sv - self-checking bench for pkt_arbiter with packet-level reference model
module tb_pkt_arbiter;

    localparam int MAXL  = 64;
    localparam int NPKT  = 64;
    localparam int NBYTE = 128;

    typedef struct {
        int port;
        int idx;
        int olen;
        bit err;
    } exp_pkt_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        f_rdy  [2];
    logic [8:0]  f_data [2];
    logic        f_tsn  [2];
    logic [18:0] f_ts   [2];
    logic        o_p0_rd, o_p1_rd;
    logic        out_ready;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [18:0] ov_rec_ts;
    logic        o_tsn_en, o_pkt_pulse, o_err_pulse;
    logic [1:0]  ov_state;

    // Upstream FIFO contents, one packet list per port
    logic [7:0]  pkt_byte [2][NPKT][NBYTE];
    int          pkt_len  [2][NPKT];
    logic        pkt_tsn  [2][NPKT];
    logic [18:0] pkt_ts   [2][NPKT];
    int          n_pkt [2];
    int          rd_pkt [2];
    int          rd_byte [2];

    exp_pkt_t    exp_q[$];
    exp_pkt_t    cur;
    int          m_last;
    int          m_ptr [2];
    int          obs_len;
    bit          prev_tail;
    bit          last_rd [2];
    bit          last_wr;
    int          first_grant;
    int          err_seen;
    bit          rand_ordy;
    int          checks, errors;

    always #5 clk_sys = ~clk_sys;

    pkt_arbiter #(.MAX_LEN(MAXL)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .i_p0_pkt_ready(f_rdy[0]), .iv_p0_data(f_data[0]), .i_p0_tsn(f_tsn[0]), .iv_p0_ts(f_ts[0]), .o_p0_rd(o_p0_rd),
        .i_p1_pkt_ready(f_rdy[1]), .iv_p1_data(f_data[1]), .i_p1_tsn(f_tsn[1]), .iv_p1_ts(f_ts[1]), .o_p1_rd(o_p1_rd),
        .i_out_ready(out_ready), .ov_data(ov_data), .o_data_wr(o_data_wr), .ov_rec_ts(ov_rec_ts),
        .o_tsn_en(o_tsn_en), .o_pkt_pulse(o_pkt_pulse), .o_err_pulse(o_err_pulse), .ov_state(ov_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int p, input int len, input bit tsn);
        chk("pkt_storage_room", n_pkt[p] < NPKT, 1);
        if (n_pkt[p] < NPKT) begin
            for (int j = 0; j < len; j++) pkt_byte[p][n_pkt[p]][j] = 8'($urandom);
            pkt_len[p][n_pkt[p]] = len;
            pkt_tsn[p][n_pkt[p]] = tsn;
            pkt_ts[p][n_pkt[p]]  = 19'($urandom_range(1, 19'h7FFFF));
            n_pkt[p]++;
        end
    endtask

    task automatic drive_fifo();
        for (int p = 0; p < 2; p++) begin
            if (rd_pkt[p] < n_pkt[p]) begin
                f_rdy[p]  = 1'b1;
                f_data[p] = {rd_byte[p] == pkt_len[p][rd_pkt[p]] - 1, pkt_byte[p][rd_pkt[p]][rd_byte[p]]};
                f_tsn[p]  = pkt_tsn[p][rd_pkt[p]];
                f_ts[p]   = pkt_ts[p][rd_pkt[p]];
            end else begin
                f_rdy[p]  = 1'b0;
                f_data[p] = 9'd0;
                f_tsn[p]  = 1'b0;
                f_ts[p]   = 19'd0;
            end
        end
    endtask

    task automatic pop(input int p, input bit rd);
        if (rd) begin
            chk("pop_from_nonempty_fifo", rd_pkt[p] < n_pkt[p], 1);
            if (rd_pkt[p] < n_pkt[p]) begin
                if (rd_byte[p] == pkt_len[p][rd_pkt[p]] - 1) begin
                    rd_pkt[p]++;
                    rd_byte[p] = 0;
                end else begin
                    rd_byte[p]++;
                end
            end
        end
    endtask

    // Packet-level model: order of grants from the preloaded queues and what each emits.
    task automatic predict();
        exp_pkt_t e;
        int g;
        bit r0, r1, t0, t1;
        m_ptr[0] = rd_pkt[0];
        m_ptr[1] = rd_pkt[1];
        while (m_ptr[0] < n_pkt[0] || m_ptr[1] < n_pkt[1]) begin
            r0 = m_ptr[0] < n_pkt[0];
            r1 = m_ptr[1] < n_pkt[1];
            t0 = r0 && pkt_tsn[0][m_ptr[0]];
            t1 = r1 && pkt_tsn[1][m_ptr[1]];
            if (r0 && r1) g = (m_last == 0) ? 1 : 0;
            else g = r1 ? 1 : 0;
`ifdef TSN_PRIORITY_EN
            if (t0 != t1) g = t1 ? 1 : 0;
`endif
            e.port = g;
            e.idx  = m_ptr[g];
            e.olen = (pkt_len[g][m_ptr[g]] > MAXL) ? MAXL : pkt_len[g][m_ptr[g]];
            e.err  = pkt_len[g][m_ptr[g]] > MAXL;
            exp_q.push_back(e);
            m_last = g;
            m_ptr[g]++;
        end
    endtask

    task automatic monitor();
        int bi;
        bit tail_exp;
        if (prev_tail) chk("gap_after_tail", o_data_wr, 0);
        if (o_data_wr === 1'b1) begin
            if (obs_len == 0) begin
                chk("expected_pkt_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                chk("first_byte_ts", ov_rec_ts, pkt_ts[cur.port][cur.idx]);
            end else begin
                chk("ts_zero_after_first", ov_rec_ts, 0);
            end
            bi = (obs_len < NBYTE) ? obs_len : NBYTE - 1;
            tail_exp = (obs_len == cur.olen - 1);
            chk("data_word", ov_data, {tail_exp, pkt_byte[cur.port][cur.idx][bi]});
            chk("tsn_en", o_tsn_en, pkt_tsn[cur.port][cur.idx]);
            chk("pkt_pulse", o_pkt_pulse, tail_exp);
            chk("err_pulse", o_err_pulse, tail_exp && cur.err);
            if (o_err_pulse === 1'b1) err_seen++;
            obs_len++;
            if (ov_data[8] === 1'b1) obs_len = 0;
            prev_tail = (ov_data[8] === 1'b1);
        end else begin
            if (obs_len != 0) chk("contiguous_packet", o_data_wr, 1);
            obs_len = 0;
            chk("idle_data_zero", ov_data, 0);
            chk("idle_ts_zero", ov_rec_ts, 0);
            chk("idle_pkt_pulse", o_pkt_pulse, 0);
            chk("idle_err_pulse", o_err_pulse, 0);
            prev_tail = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk_sys);
        monitor();
        last_rd[0] = o_p0_rd;
        last_rd[1] = o_p1_rd;
        last_wr    = o_data_wr;
        if (first_grant < 0 && (o_p0_rd || o_p1_rd)) first_grant = o_p1_rd ? 1 : 0;
        @(posedge clk_sys);
        #1;
        pop(0, last_rd[0]);
        pop(1, last_rd[1]);
        drive_fifo();
        if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && obs_len == 0 && rd_pkt[0] == n_pkt[0] &&
                 rd_pkt[1] == n_pkt[1] && ov_state == 2'd0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", n < budget, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ov_data"}, ov_data, 0);
        chk({tag, "_o_data_wr"}, o_data_wr, 0);
        chk({tag, "_ov_rec_ts"}, ov_rec_ts, 0);
        chk({tag, "_o_tsn_en"}, o_tsn_en, 0);
        chk({tag, "_o_pkt_pulse"}, o_pkt_pulse, 0);
        chk({tag, "_o_err_pulse"}, o_err_pulse, 0);
        chk({tag, "_ov_state"}, ov_state, 0);
        chk({tag, "_o_p0_rd"}, o_p0_rd, 0);
        chk({tag, "_o_p1_rd"}, o_p1_rd, 0);
    endtask

    initial begin
        int n;
        int e0;
        checks = 0; errors = 0;
        n_pkt = '{0, 0}; rd_pkt = '{0, 0}; rd_byte = '{0, 0};
        obs_len = 0; prev_tail = 0; err_seen = 0; rand_ordy = 0; m_last = 1;
        first_grant = -1;
        reset_n = 1'b0;
        out_ready = 1'b0;
        drive_fifo();
        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("reset");

        // Both ports hold a 64-byte packet from reset; p1's is TSN.
        load(0, 64, 1'b0);
        load(1, 64, 1'b1);
        drive_fifo();
        out_ready = 1'b1;
        predict();
        first_grant = -1;
        reset_n = 1'b1;
        drain(400);
`ifdef TSN_PRIORITY_EN
        chk("first_tie_grant", first_grant, 1);
`else
        chk("first_tie_grant", first_grant, 0);
`endif

        // Downstream not ready: no pop until IDLE has seen i_out_ready.
        out_ready = 1'b0;
        load(0, 40, 1'b0);
        drive_fifo();
        predict();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("no_pop_while_not_ready", last_rd[0], 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("no_pop_before_ready_seen", last_rd[0], 0);
        cycle();
        chk("pop_after_ready_seen", last_rd[0], 1);
        chk("no_output_on_pop_cycle", last_wr, 0);
        cycle();
        chk("output_one_cycle_after_pop", last_wr, 1);
        drain(400);

        // Over-length packets on p1, around the MAX_LEN boundary.
        e0 = err_seen;
        load(1, 100, 1'b0);
        load(1, 64, 1'b1);
        load(1, 65, 1'b0);
        load(1, 30, 1'b0);
        drive_fifo();
        predict();
        drain(800);
        chk("err_pulse_count", err_seen - e0, 2);
        chk("p1_fully_popped", rd_pkt[1], n_pkt[1]);

        // Randomized traffic on both ports with a flickering i_out_ready.
        for (int i = 0; i < 16; i++) begin
            load(0, $urandom_range(1, 90), 1'($urandom_range(0, 1)));
            load(1, $urandom_range(1, 90), 1'($urandom_range(0, 1)));
        end
        drive_fifo();
        predict();
        rand_ordy = 1'b1;
        drain(8000);
        rand_ordy = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a packet.
        load(0, 40, 1'b0);
        drive_fifo();
        predict();
        n = 0;
        while (obs_len < 20 && n < 200) begin
            cycle();
            n++;
        end
        chk("reached_byte_20", obs_len, 20);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        n_pkt = '{0, 0}; rd_pkt = '{0, 0}; rd_byte = '{0, 0};
        exp_q.delete();
        obs_len = 0; prev_tail = 0; m_last = 1;
        drive_fifo();
        @(posedge clk_sys);
        #1;
        check_all_zero("held_reset");
        load(0, 20, 1'b0);
        load(1, 20, 1'b0);
        drive_fifo();
        predict();
        first_grant = -1;
        reset_n = 1'b1;
        drain(400);
        chk("tie_after_reset_grant", first_grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
